drive_supervisor: RTL and testbench

Clocked supervisor that sequences the vehicle drive/compute status logic. It filters `cpu_overheated`, `arrived`, `gas_tank_empty` and driver/refuel requests into a registered Moore state machine. It produces `shut_off_computer` and `keep_driving` with defined cooldown, refuel and trip-count behaviour. It sits between the raw sensor flags and the drive actuators, replacing the purely combinational decode.

---
 rtl/drive_supervisor.sv | 180 ++++++++++++++++++
 tb/tb_drive_supervisor.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/drive_supervisor.sv
// drive_supervisor: registered Moore FSM sequencing the drive/compute status.
//
// Filters the raw thermal flag, sequences trips through drive, refuel, thermal
// shutdown and arrival, and decodes the actuator outputs from the registered state.
//
// Optional feature macro: REFUEL_TIMEOUT_EN. When defined, STOP_FUEL aborts to DONE
// after REFUEL_TIMEOUT cycles without a valid refuel and raises the sticky fault flag.
// When undefined, STOP_FUEL waits indefinitely and fault is tied low.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   start               driver request to begin a trip (level)
//   cpu_overheated      raw thermal flag
//   arrived             destination reached
//   gas_tank_empty      fuel flag
//   refuel_done         refuel complete (pulse or level)
//   keep_driving        high only in DRIVE
//   shut_off_computer   high only in SHUTDOWN
//   state               current state encoding (IDLE=0 .. DONE=4)
//   trip_count          completed trips, saturating
//   fault               sticky refuel-timeout flag
module drive_supervisor #(
  parameter int unsigned OVERHEAT_FILT   = 3,
  parameter int unsigned COOLDOWN_CYCLES = 16,
  parameter int unsigned REFUEL_TIMEOUT  = 64,
  parameter int unsigned TRIP_W          = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              cpu_overheated,
  input  logic              arrived,
  input  logic              gas_tank_empty,
  input  logic              refuel_done,
  output logic              keep_driving,
  output logic              shut_off_computer,
  output logic [2:0]        state,
  output logic [TRIP_W-1:0] trip_count,
  output logic              fault
);

  localparam int unsigned OvhW  = $clog2(OVERHEAT_FILT) + 1;
  localparam int unsigned CoolW = $clog2(COOLDOWN_CYCLES) + 1;

  localparam logic [OvhW-1:0]  OvhMax   = OvhW'(OVERHEAT_FILT - 1);
  localparam logic [CoolW-1:0] CoolLoad = CoolW'(COOLDOWN_CYCLES);

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StDrive    = 3'd1,
    StStopFuel = 3'd2,
    StShutdown = 3'd3,
    StDone     = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [OvhW-1:0]    ovh_cnt_q, ovh_cnt_d;
  logic [CoolW-1:0]   cool_cnt_q, cool_cnt_d;
  logic [TRIP_W-1:0]  trip_q, trip_d;
  logic               ovh_trig;

`ifdef REFUEL_TIMEOUT_EN
  localparam int unsigned FuelW   = $clog2(REFUEL_TIMEOUT) + 1;
  localparam logic [FuelW-1:0] FuelMax = FuelW'(REFUEL_TIMEOUT - 1);

  logic [FuelW-1:0] fuel_cnt_q, fuel_cnt_d;
  logic             fault_q, fault_d;
`endif

  // Overheat filter: counts consecutive high samples, any low sample restarts it.
  always_comb begin
    ovh_cnt_d = '0;
    if (cpu_overheated) begin
      ovh_cnt_d = (ovh_cnt_q == OvhMax) ? ovh_cnt_q : ovh_cnt_q + 1'b1;
    end
  end

  assign ovh_trig = cpu_overheated && (ovh_cnt_q == OvhMax);

  always_comb begin
    state_d    = state_q;
    cool_cnt_d = cool_cnt_q;
    trip_d     = trip_q;
`ifdef REFUEL_TIMEOUT_EN
    fuel_cnt_d = fuel_cnt_q;
    fault_d    = fault_q;
`endif
    if (ovh_trig && (state_q != StShutdown)) begin
      // Thermal shutdown pre-empts everything, including arrival and refuel.
      state_d    = StShutdown;
      cool_cnt_d = CoolLoad;
    end else begin
      case (state_q)
        StIdle: begin
          if (start && !arrived && !gas_tank_empty) begin
            state_d = StDrive;
`ifdef REFUEL_TIMEOUT_EN
            fault_d = 1'b0;
`endif
          end
        end
        StDrive: begin
          if (arrived) begin
            state_d = StDone;
            if (trip_q != '1) trip_d = trip_q + 1'b1;
          end else if (gas_tank_empty) begin
            state_d = StStopFuel;
`ifdef REFUEL_TIMEOUT_EN
            fuel_cnt_d = '0;
`endif
          end
        end
        StStopFuel: begin
`ifdef REFUEL_TIMEOUT_EN
          fuel_cnt_d = fuel_cnt_q + 1'b1;
`endif
          if (refuel_done && !gas_tank_empty) begin
            state_d = StDrive;
`ifdef REFUEL_TIMEOUT_EN
          end else if (fuel_cnt_q == FuelMax) begin
            state_d = StDone;
            fault_d = 1'b1;
`endif
          end
        end
        StShutdown: begin
          if (cpu_overheated) begin
            cool_cnt_d = CoolLoad;
          end else begin
            cool_cnt_d = cool_cnt_q - 1'b1;
            // <= 1 rather than == 1 so a corrupted zero count cannot stall the exit.
            if (cool_cnt_q <= CoolW'(1)) state_d = StIdle;
          end
        end
        StDone: begin
          if (!start) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      ovh_cnt_q  <= '0;
      cool_cnt_q <= '0;
      trip_q     <= '0;
    end else begin
      state_q    <= state_d;
      ovh_cnt_q  <= ovh_cnt_d;
      cool_cnt_q <= cool_cnt_d;
      trip_q     <= trip_d;
    end
  end

`ifdef REFUEL_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fuel_cnt_q <= '0;
      fault_q    <= 1'b0;
    end else begin
      fuel_cnt_q <= fuel_cnt_d;
      fault_q    <= fault_d;
    end
  end

  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

  always_comb begin
    state             = state_q;
    keep_driving      = (state_q == StDrive);
    shut_off_computer = (state_q == StShutdown);
    trip_count        = trip_q;
  end

endmodule

// File: tb/tb_drive_supervisor.sv
// Directed bench for drive_supervisor with small parameters so every
// boundary (filter length, cooldown, refuel timeout, trip saturation) is reachable.
module tb_drive_supervisor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, cpu_overheated, arrived, gas_tank_empty, refuel_done;
  logic       keep_driving, shut_off_computer, fault;
  logic [2:0] state;
  logic [1:0] trip_count;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_trip = 0;

  localparam int SIdle = 0, SDrive = 1, SStop = 2, SShut = 3, SDone = 4;

  drive_supervisor #(
    .OVERHEAT_FILT  (2),
    .COOLDOWN_CYCLES(4),
    .REFUEL_TIMEOUT (8),
    .TRIP_W         (2)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .cpu_overheated   (cpu_overheated),
    .arrived          (arrived),
    .gas_tank_empty   (gas_tank_empty),
    .refuel_done      (refuel_done),
    .keep_driving     (keep_driving),
    .shut_off_computer(shut_off_computer),
    .state            (state),
    .trip_count       (trip_count),
    .fault            (fault)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Full state + output check against the expected state.
  task automatic chk_st(input string tag, input int exp_st);
    chk({tag, ".state"}, {29'd0, state}, exp_st);
    chk({tag, ".keep"}, {31'd0, keep_driving}, (exp_st == SDrive) ? 1 : 0);
    chk({tag, ".shut"}, {31'd0, shut_off_computer}, (exp_st == SShut) ? 1 : 0);
  endtask

  task automatic do_trip(input string tag);
    start = 1'b1;
    tick();
    chk_st({tag, ".drive"}, SDrive);
    start   = 1'b0;
    arrived = 1'b1;
    tick();
    if (exp_trip < 3) exp_trip++;
    chk_st({tag, ".done"}, SDone);
    chk({tag, ".trip"}, {30'd0, trip_count}, exp_trip);
    arrived = 1'b0;
    tick();
    chk_st({tag, ".idle"}, SIdle);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0; cpu_overheated = 1'b0; arrived = 1'b0;
    gas_tank_empty = 1'b0; refuel_done = 1'b0;
    #1;
    chk_st("rst", SIdle);
    chk("rst.trip", {30'd0, trip_count}, 0);
    chk("rst.fault", {31'd0, fault}, 0);
    tick(2);
    rst_n = 1'b1;
    tick();

    // Normal trip: three cycles of DRIVE, then arrival.
    start = 1'b1;
    tick();
    chk_st("trip.d1", SDrive);
    tick();
    chk_st("trip.d2", SDrive);
    tick();
    chk_st("trip.d3", SDrive);
    arrived = 1'b1;
    tick();
    exp_trip = 1;
    chk_st("trip.done", SDone);
    chk("trip.count", {30'd0, trip_count}, exp_trip);
    tick();
    chk_st("trip.hold_start", SDone);
    start = 1'b0; arrived = 1'b0;
    tick();
    chk_st("trip.idle", SIdle);

    // Overheat filter: 1,0,1,1 during DRIVE.
    start = 1'b1;
    tick();
    chk_st("ovh.drive", SDrive);
    start = 1'b0;
    cpu_overheated = 1'b1; tick(); chk_st("ovh.p1", SDrive);
    cpu_overheated = 1'b0; tick(); chk_st("ovh.p0", SDrive);
    cpu_overheated = 1'b1; tick(); chk_st("ovh.p1b", SDrive);
    tick();
    chk_st("ovh.shut", SShut);

    // Cooldown reload: low 3, high 1, low 4.
    cpu_overheated = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_st("cool.low_a", SShut);
    end
    cpu_overheated = 1'b1; tick(); chk_st("cool.reload", SShut);
    cpu_overheated = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_st("cool.low_b", SShut);
    end
    tick();
    chk_st("cool.exit", SIdle);
    chk("cool.trip", {30'd0, trip_count}, exp_trip);

    // Refuel: pulse while still empty is ignored, pulse after refill resumes.
    start = 1'b1; tick(); chk_st("fuel.drive", SDrive);
    start = 1'b0;
    gas_tank_empty = 1'b1; tick(); chk_st("fuel.stop", SStop);
    refuel_done = 1'b1; tick(); chk_st("fuel.ignored", SStop);
    refuel_done = 1'b0; gas_tank_empty = 1'b0; tick(); chk_st("fuel.wait", SStop);
    refuel_done = 1'b1; tick(); chk_st("fuel.resume", SDrive);
    refuel_done = 1'b0;
    arrived = 1'b1; tick();
    exp_trip = 2;
    chk_st("fuel.done", SDone);
    chk("fuel.trip", {30'd0, trip_count}, exp_trip);
    arrived = 1'b0; tick(); chk_st("fuel.idle", SIdle);

    // Priority: arrival and overheat trigger on the same edge -> SHUTDOWN, no count.
    start = 1'b1; tick(); chk_st("prio.drive", SDrive);
    start = 1'b0;
    cpu_overheated = 1'b1; tick(); chk_st("prio.filt", SDrive);
    arrived = 1'b1; tick();
    chk_st("prio.shut", SShut);
    chk("prio.trip", {30'd0, trip_count}, exp_trip);
    arrived = 1'b0; cpu_overheated = 1'b0;
    tick();
    // Reset mid-SHUTDOWN takes effect without waiting for an edge.
    #2 rst_n = 1'b0;
    #1;
    chk_st("rst_mid", SIdle);
    chk("rst_mid.trip", {30'd0, trip_count}, 0);
    chk("rst_mid.fault", {31'd0, fault}, 0);
    exp_trip = 0;
    tick();
    rst_n = 1'b1;
    tick();
    chk_st("rst_mid.after", SIdle);

    // Refuel timeout: no refuel for 8 edges in STOP_FUEL.
    start = 1'b1; tick(); chk_st("tmo.drive", SDrive);
    start = 1'b0;
    gas_tank_empty = 1'b1; tick(); chk_st("tmo.stop", SStop);
    for (int i = 0; i < 7; i++) begin
      tick();
      chk_st("tmo.wait", SStop);
    end
    tick();
`ifdef REFUEL_TIMEOUT_EN
    chk_st("tmo.done", SDone);
    chk("tmo.fault", {31'd0, fault}, 1);
    chk("tmo.trip", {30'd0, trip_count}, exp_trip);
    gas_tank_empty = 1'b0;
    tick();
    chk_st("tmo.idle", SIdle);
    chk("tmo.fault_sticky", {31'd0, fault}, 1);
    start = 1'b1; tick();
    chk_st("tmo.relaunch", SDrive);
    chk("tmo.fault_clr", {31'd0, fault}, 0);
    start = 1'b0;
    arrived = 1'b1; tick();
    exp_trip++;
    chk("tmo.trip2", {30'd0, trip_count}, exp_trip);
    arrived = 1'b0; tick();
    chk_st("tmo.idle2", SIdle);
`else
    chk_st("tmo.waits", SStop);
    chk("tmo.nofault", {31'd0, fault}, 0);
    gas_tank_empty = 1'b0; refuel_done = 1'b1; tick();
    chk_st("tmo.resume", SDrive);
    refuel_done = 1'b0;
    arrived = 1'b1; tick();
    exp_trip++;
    chk("tmo.trip", {30'd0, trip_count}, exp_trip);
    arrived = 1'b0; tick();
    chk_st("tmo.idle", SIdle);
`endif

    // Five more trips: count must saturate at 3.
    for (int t = 0; t < 5; t++) do_trip("sat");
    chk("sat.final", {30'd0, trip_count}, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
